// File: rtl/sc_scaled_adder_n.sv
// N-input stochastic scaled adder: each output bit is 1 with probability sum(P(x[i]))/N.
// A residue accumulator carries the fractional part of the input popcount from cycle to cycle.
module sc_scaled_adder_n #(
  parameter int N_INPUTS   = 4,
  parameter int ACC_INIT   = N_INPUTS / 2,
  parameter int STREAM_LEN = 256,
  parameter bit AUTO_CLEAR = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic [N_INPUTS-1:0] x,
  output logic                out,
  output logic                out_valid,
  output logic                last
);

  localparam int ACC_W = $clog2(2 * N_INPUTS);
  localparam int CNT_W = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;

  localparam logic [ACC_W-1:0] ACC_RST  = ACC_W'(ACC_INIT);
  localparam logic [ACC_W-1:0] N_VAL    = ACC_W'(N_INPUTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STREAM_LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0] sum_p0;
  logic [ACC_W-1:0] res_p0;
  logic             bit_p0;
  logic             last_p0;

  function automatic logic [ACC_W-1:0] popcount(input logic [N_INPUTS-1:0] v);
    logic [ACC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_INPUTS; i++) c = c + ACC_W'(v[i]);
    return c;
  endfunction

  // Emit a 1 whenever the running sum reaches N; keep the remainder as residue.
  function automatic logic [ACC_W:0] scale_step(input logic [ACC_W-1:0] s);
    if (s >= N_VAL) return {1'b1, s - N_VAL};
    return {1'b0, s};
  endfunction

  // Stage p0: combine residue with this cycle's inputs
  always_comb begin
    sum_p0           = acc + popcount(x);
    {bit_p0, res_p0} = scale_step(sum_p0);
    last_p0          = (cnt == CNT_LAST);
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc       <= ACC_RST;
      cnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      last      <= 1'b0;
    end else if (en) begin
      out       <= bit_p0;
      out_valid <= 1'b1;
      last      <= last_p0;
      if (last_p0) begin
        cnt <= '0;
        acc <= AUTO_CLEAR ? ACC_RST : res_p0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= res_p0;
      end
    end else begin
      out_valid <= 1'b0;
      last      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sc_scaled_adder_n.sv
// Directed bench for sc_scaled_adder_n: vector table on a 4-input, 4-bit-stream instance,
// plus sequences for the 2-input toggle case, single-bit streams and an 8-input random stream.
module tb_sc_scaled_adder_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r2, c2, e2;
  logic [1:0] x2;
  logic       o2, v2, l2;

  logic       r4, c4, e4;
  logic [3:0] x4;
  logic       o4, v4, l4;
  logic       o1, v1, l1;

  logic       r8, c8, e8;
  logic [7:0] x8;
  logic       o8, v8, l8;

  sc_scaled_adder_n #(.N_INPUTS(2), .ACC_INIT(1), .STREAM_LEN(256), .AUTO_CLEAR(1'b1)) u2 (
    .clk(clk), .rst(r2), .clear(c2), .en(e2), .x(x2), .out(o2), .out_valid(v2), .last(l2));

  sc_scaled_adder_n #(.N_INPUTS(4), .ACC_INIT(2), .STREAM_LEN(4), .AUTO_CLEAR(1'b1)) u4 (
    .clk(clk), .rst(r4), .clear(c4), .en(e4), .x(x4), .out(o4), .out_valid(v4), .last(l4));

  sc_scaled_adder_n #(.N_INPUTS(4), .ACC_INIT(2), .STREAM_LEN(1), .AUTO_CLEAR(1'b1)) u1 (
    .clk(clk), .rst(r4), .clear(c4), .en(e4), .x(x4), .out(o1), .out_valid(v1), .last(l1));

  sc_scaled_adder_n #(.N_INPUTS(8), .ACC_INIT(4), .STREAM_LEN(256), .AUTO_CLEAR(1'b1)) u8 (
    .clk(clk), .rst(r8), .clear(c8), .en(e8), .x(x8), .out(o8), .out_valid(v8), .last(l8));

  typedef struct {
    logic       rst, clr, en;
    logic [3:0] x;
    int         out, vld, lst, acc, cnt;
  } vec_t;

  vec_t tv[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic e, input logic [3:0] xv,
                     input int o, input int v, input int l, input int a, input int n);
    vec_t t;
    t.rst = r; t.clr = c; t.en = e; t.x = xv;
    t.out = o; t.vld = v; t.lst = l; t.acc = a; t.cnt = n;
    tv.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p[8];
    int ones8, tot8, vcnt, cyc, vld_err, last_err, lasts;

    r2 = 0; c2 = 0; e2 = 0; x2 = '0;
    r4 = 0; c4 = 0; e4 = 0; x4 = '0;
    r8 = 0; c8 = 0; e8 = 0; x8 = '0;

    // ---- 2-input toggle adder ----
    r2 = 1; tick();
    chk("u2 reset out", o2, 0);
    chk("u2 reset valid", v2, 0);
    r2 = 0; e2 = 1; x2 = 2'b00; tick();
    chk("u2 x=00 out", o2, 0);
    chk("u2 x=00 valid", v2, 1);
    for (int k = 0; k < 6; k++) begin
      x2 = 2'b01; tick();
      chk($sformatf("u2 x=01 bit%0d", k), o2, (k % 2 == 0) ? 1 : 0);
    end
    x2 = 2'b11; tick(); chk("u2 x=11 a", o2, 1);
    tick();             chk("u2 x=11 b", o2, 1);
    x2 = 2'b10; tick(); chk("u2 x=10 a", o2, 1);
    tick();             chk("u2 x=10 b", o2, 0);
    e2 = 0;

    // ---- 4-input table: rst clr en x | out vld last acc cnt ----
    add(1, 0, 0, 4'b0000, 0, 0, 0, 2, 0);
    add(0, 0, 1, 4'b0001, 0, 1, 0, 3, 1);
    add(0, 0, 1, 4'b0001, 1, 1, 0, 0, 2);
    add(0, 0, 1, 4'b0001, 0, 1, 0, 1, 3);
    add(0, 0, 1, 4'b0001, 0, 1, 1, 2, 0);
    add(0, 0, 1, 4'b0001, 0, 1, 0, 3, 1);
    add(0, 0, 1, 4'b0001, 1, 1, 0, 0, 2);
    add(0, 0, 1, 4'b0001, 0, 1, 0, 1, 3);
    add(0, 0, 1, 4'b0001, 0, 1, 1, 2, 0);
    add(0, 0, 1, 4'b1111, 1, 1, 0, 2, 1);
    add(0, 0, 1, 4'b1111, 1, 1, 0, 2, 2);
    add(0, 0, 1, 4'b1111, 1, 1, 0, 2, 3);
    add(0, 0, 1, 4'b1111, 1, 1, 1, 2, 0);
    add(0, 0, 1, 4'b1111, 1, 1, 0, 2, 1);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 2, 2);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 2, 3);
    add(0, 0, 1, 4'b0000, 0, 1, 1, 2, 0);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 2, 1);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 2, 2);
    add(1, 0, 0, 4'b0000, 0, 0, 0, 2, 0);
    add(0, 0, 1, 4'b0001, 0, 1, 0, 3, 1);
    add(0, 0, 0, 4'b1111, 0, 0, 0, 3, 1);
    add(0, 0, 1, 4'b0001, 1, 1, 0, 0, 2);
    add(0, 0, 1, 4'b0001, 0, 1, 0, 1, 3);
    add(0, 0, 0, 4'b1111, 0, 0, 0, 1, 3);
    add(0, 0, 1, 4'b0011, 0, 1, 1, 2, 0);
    add(0, 0, 1, 4'b0001, 0, 1, 0, 3, 1);
    add(0, 1, 1, 4'b1111, 0, 0, 0, 2, 0);
    add(0, 0, 1, 4'b0001, 0, 1, 0, 3, 1);
    add(0, 0, 1, 4'b1111, 1, 1, 0, 3, 2);
    add(0, 0, 0, 4'b0000, 1, 0, 0, 3, 2);
    add(1, 0, 1, 4'b1111, 0, 0, 0, 2, 0);
    add(0, 0, 1, 4'b0001, 0, 1, 0, 3, 1);
    add(0, 0, 1, 4'b1111, 1, 1, 0, 3, 2);
    add(1, 1, 1, 4'b1111, 0, 0, 0, 2, 0);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 2, 1);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 2, 2);
    add(0, 0, 1, 4'b0000, 0, 1, 0, 2, 3);
    add(0, 0, 1, 4'b0000, 0, 1, 1, 2, 0);

    foreach (tv[i]) begin
      r4 = tv[i].rst; c4 = tv[i].clr; e4 = tv[i].en; x4 = tv[i].x;
      tick();
      chk($sformatf("v%0d out", i), o4, tv[i].out);
      chk($sformatf("v%0d valid", i), v4, tv[i].vld);
      chk($sformatf("v%0d last", i), l4, tv[i].lst);
      chk($sformatf("v%0d acc", i), int'(u4.acc), tv[i].acc);
      chk($sformatf("v%0d cnt", i), int'(u4.cnt), tv[i].cnt);
    end

    // ---- single-bit streams: last on every valid bit, residue reloaded each bit ----
    r4 = 1; c4 = 0; e4 = 0; x4 = '0; tick();
    chk("u1 reset last", l1, 0);
    r4 = 0; e4 = 1; x4 = 4'b0011; tick();
    chk("u1 b0 out", o1, 1); chk("u1 b0 last", l1, 1); chk("u1 b0 valid", v1, 1);
    e4 = 0; x4 = 4'b0000; tick();
    chk("u1 stall last", l1, 0); chk("u1 stall valid", v1, 0); chk("u1 stall out", o1, 1);
    e4 = 1; x4 = 4'b0001; tick();
    chk("u1 b1 out", o1, 0); chk("u1 b1 last", l1, 1);
    tick();
    chk("u1 b2 out", o1, 0); chk("u1 b2 last", l1, 1);
    e4 = 0;

    // ---- 8-input random stream with stalls ----
    foreach (p[i]) p[i] = int'($urandom_range(0, 100));
    r8 = 1; tick();
    r8 = 0;
    ones8 = 0; tot8 = 0; vcnt = 0; cyc = 0; vld_err = 0; last_err = 0; lasts = 0;
    while (vcnt < 256 && cyc < 4000) begin
      e8 = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 8; i++) x8[i] = (int'($urandom_range(0, 99)) < p[i]);
      tick();
      cyc++;
      if (e8) begin
        vcnt++;
        tot8 += $countones(x8);
      end
      if (v8 !== e8) vld_err++;
      if (l8 !== (e8 && vcnt == 256)) last_err++;
      if (l8) lasts++;
      if (v8) ones8 += int'(o8);
    end
    e8 = 0;
    chk("u8 stream completed", vcnt, 256);
    chk("u8 valid tracks en errors", vld_err, 0);
    chk("u8 last placement errors", last_err, 0);
    chk("u8 last count", lasts, 1);
    chk("u8 ones count", ones8, (4 + tot8) / 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
